// File: rtl/picobus_pkg.sv
// Shared types, constants and helpers for the picorv32 native-bus interconnect.
package picobus_pkg;

    // Transaction FSM states of the interconnect.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_ERR    = 2'd2
    } state_e;

    // Read data handed back to the master when an access is terminated with an error.
    localparam logic [31:0] DEFAULT_ERR_RDATA = 32'hDEAD_BEEF;

    // Address window match: masked address equals the window base.
    function automatic logic win_hit(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] mask);
        return ((addr & mask) == base);
    endfunction

endpackage

// File: rtl/picobus_addr_decode.sv
// Combinational priority address decoder; the lowest matching slave index wins.
module picobus_addr_decode
    import picobus_pkg::*;
#(
    parameter int                     N_SLAVES = 4,
    parameter int                     IDX_W    = 2,
    parameter logic [N_SLAVES*32-1:0] SLV_BASE = '0,
    parameter logic [N_SLAVES*32-1:0] SLV_MASK = '0
) (
    input  logic [31:0]      mem_addr,
    output logic             hit,
    output logic [IDX_W-1:0] idx
);

    // Scan from the highest index down so a lower matching index overrides a higher one.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if (win_hit(mem_addr, SLV_BASE[32*i +: 32], SLV_MASK[32*i +: 32])) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end else begin
            end
        end
    end

endmodule

// File: rtl/picobus_interconnect.sv
// Single-master, N-slave picorv32 native-bus interconnect with latched slave
// selection, access timeout and sticky error reporting.
module picobus_interconnect
    import picobus_pkg::*;
#(
    parameter int                     N_SLAVES       = 4,
    parameter logic [N_SLAVES*32-1:0] SLV_BASE       = {32'h8000_0010, 32'h8000_0008,
                                                        32'h8000_0000, 32'h0000_0000},
    parameter logic [N_SLAVES*32-1:0] SLV_MASK       = {32'hFFFF_FFFC, 32'hFFFF_FFF8,
                                                        32'hFFFF_FFFF, 32'hFFFF_E000},
    parameter int                     TIMEOUT_CYCLES = 256,
    parameter logic [31:0]            ERR_RDATA      = DEFAULT_ERR_RDATA
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   mem_valid,
    input  logic                   mem_instr,
    input  logic [31:0]            mem_addr,
    input  logic [31:0]            mem_wdata,
    input  logic [3:0]             mem_wstrb,
    output logic                   mem_ready,
    output logic [31:0]            mem_rdata,
    output logic [N_SLAVES-1:0]    slv_sel,
    output logic [31:0]            slv_addr,
    output logic [31:0]            slv_wdata,
    output logic [3:0]             slv_wstrb,
    input  logic [N_SLAVES*32-1:0] slv_rdata,
    input  logic [N_SLAVES-1:0]    slv_ready,
    input  logic                   err_clr,
    output logic                   bus_err,
    output logic [31:0]            err_addr,
    output logic                   err_instr,
    output logic                   err_irq
);

    localparam int IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    // A zero timeout still needs a 1-bit counter to keep the vector legal.
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ?
                                            CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    state_e              state_r, state_nxt_s;
    logic [IDX_W-1:0]    idx_r, idx_nxt_s;
    logic [N_SLAVES-1:0] sel_r, sel_nxt_s;
    logic [CNT_W-1:0]    cnt_r, cnt_nxt_s;
    logic                bus_err_r, err_instr_r, err_irq_r;
    logic [31:0]         err_addr_r;
    logic                dec_hit_s;
    logic [IDX_W-1:0]    dec_idx_s;
    logic                sel_ready_s;
    logic [31:0]         sel_rdata_s;
    logic                err_enter_s;

    picobus_addr_decode #(
        .N_SLAVES (N_SLAVES),
        .IDX_W    (IDX_W),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_decode (
        .mem_addr (mem_addr),
        .hit      (dec_hit_s),
        .idx      (dec_idx_s)
    );

    // Only the latched slave's handshake is ever looked at.
    assign sel_ready_s = slv_ready[idx_r];
    assign sel_rdata_s = slv_rdata[32*int'(idx_r) +: 32];
    assign err_enter_s = (state_nxt_s == ST_ERR);

    // Next-state logic: decode in IDLE, wait/timeout in ACTIVE, single-cycle ERR.
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        sel_nxt_s   = sel_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (mem_valid) begin
                    if (dec_hit_s) begin
                        state_nxt_s          = ST_ACTIVE;
                        idx_nxt_s            = dec_idx_s;
                        sel_nxt_s            = '0;
                        sel_nxt_s[dec_idx_s] = 1'b1;
                        cnt_nxt_s            = '0;
                    end else begin
                        state_nxt_s = ST_ERR;
                        sel_nxt_s   = '0;
                    end
                end else begin
                    sel_nxt_s = '0;
                end
            end
            ST_ACTIVE: begin
                if (!mem_valid) begin
                    // Master abandoned the access: drop it silently.
                    state_nxt_s = ST_IDLE;
                    sel_nxt_s   = '0;
                end else if (sel_ready_s) begin
                    // Ready takes priority over a coincident timeout.
                    state_nxt_s = ST_IDLE;
                    sel_nxt_s   = '0;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_r == CNT_LAST)) begin
                    state_nxt_s = ST_ERR;
                    sel_nxt_s   = '0;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_ERR: begin
                state_nxt_s = ST_IDLE;
                sel_nxt_s   = '0;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                sel_nxt_s   = '0;
            end
        endcase
    end

    // Master response: live slave handshake in ACTIVE, error word in ERR, idle zero otherwise.
    always_comb begin
        mem_ready = 1'b0;
        mem_rdata = 32'h0000_0000;
        case (state_r)
            ST_ACTIVE: begin
                mem_ready = sel_ready_s & mem_valid;
                mem_rdata = sel_rdata_s;
            end
            ST_ERR: begin
                mem_ready = 1'b1;
                mem_rdata = ERR_RDATA;
            end
            default: begin
                mem_ready = 1'b0;
                mem_rdata = 32'h0000_0000;
            end
        endcase
    end

    // FSM state, latched slave index, select vector and timeout counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            idx_r   <= '0;
            sel_r   <= '0;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            idx_r   <= idx_nxt_s;
            sel_r   <= sel_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Sticky error status; the first uncleared error's address is kept, a set beats a clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus_err_r   <= 1'b0;
            err_addr_r  <= 32'h0000_0000;
            err_instr_r <= 1'b0;
            err_irq_r   <= 1'b0;
        end else begin
            err_irq_r <= err_enter_s;
            if (err_enter_s) begin
                bus_err_r <= 1'b1;
                if (!bus_err_r || err_clr) begin
                    err_addr_r  <= mem_addr;
                    err_instr_r <= mem_instr;
                end else begin
                    err_addr_r  <= err_addr_r;
                    err_instr_r <= err_instr_r;
                end
            end else if (err_clr) begin
                bus_err_r <= 1'b0;
            end else begin
                bus_err_r <= bus_err_r;
            end
        end
    end

    assign slv_sel   = sel_r;
    assign slv_addr  = mem_addr;
    assign slv_wdata = mem_wdata;
    // Strobes only reach the bus while a slave is selected, so error writes are dropped.
    assign slv_wstrb = (|sel_r) ? mem_wstrb : 4'h0;
    assign bus_err   = bus_err_r;
    assign err_addr  = err_addr_r;
    assign err_instr = err_instr_r;
    assign err_irq   = err_irq_r;

endmodule

// File: tb/tb_picobus_interconnect.sv
// Directed testbench for picobus_interconnect with a response scoreboard.
module tb_picobus_interconnect;

    localparam int NS = 4;

    logic           clk;
    logic           reset_n;
    logic           mem_valid;
    logic           mem_instr;
    logic [31:0]    mem_addr;
    logic [31:0]    mem_wdata;
    logic [3:0]     mem_wstrb;
    logic           mem_ready;
    logic [31:0]    mem_rdata;
    logic [NS-1:0]  slv_sel;
    logic [31:0]    slv_addr;
    logic [31:0]    slv_wdata;
    logic [3:0]     slv_wstrb;
    logic [NS*32-1:0] slv_rdata;
    logic [NS-1:0]  slv_ready;
    logic           err_clr;
    logic           bus_err;
    logic [31:0]    err_addr;
    logic           err_instr;
    logic           err_irq;

    int n_cmp;
    int n_err;
    logic [31:0] exp_q[$];

    picobus_interconnect #(
        .N_SLAVES       (NS),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .mem_valid (mem_valid),
        .mem_instr (mem_instr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .slv_sel   (slv_sel),
        .slv_addr  (slv_addr),
        .slv_wdata (slv_wdata),
        .slv_wstrb (slv_wstrb),
        .slv_rdata (slv_rdata),
        .slv_ready (slv_ready),
        .err_clr   (err_clr),
        .bus_err   (bus_err),
        .err_addr  (err_addr),
        .err_instr (err_instr),
        .err_irq   (err_irq)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    // Advance to the middle of the next clock cycle.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Completed transfer: ready must be high and rdata must match the oldest expectation.
    task automatic chk_resp(input string tag);
        logic [31:0] exp_v;
        chk({tag, "_ready"}, 32'(mem_ready), 32'h1);
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s observed=response expected=empty_scoreboard", tag);
        end else begin
            exp_v = exp_q.pop_front();
            chk({tag, "_rdata"}, mem_rdata, exp_v);
        end
    endtask

    task automatic request(input logic [31:0] addr, input logic [3:0] wstrb,
                           input logic instr, input logic [31:0] exp_rdata);
        mem_valid = 1'b1;
        mem_addr  = addr;
        mem_wstrb = wstrb;
        mem_instr = instr;
        mem_wdata = addr ^ 32'h5A5A_5A5A;
        exp_q.push_back(exp_rdata);
    endtask

    // Directed sequence of all scenarios.
    initial begin
        clk = 1'b0; reset_n = 1'b0; mem_valid = 1'b0; mem_instr = 1'b0;
        mem_addr = 32'h0; mem_wdata = 32'h0; mem_wstrb = 4'h0;
        slv_rdata = '0; slv_ready = '0; err_clr = 1'b0;
        n_cmp = 0; n_err = 0;

        repeat (3) cyc();
        #1;
        chk("rst_sel", 32'(slv_sel), 32'h0);
        chk("rst_ready", 32'(mem_ready), 32'h0);
        chk("rst_rdata", mem_rdata, 32'h0);
        chk("rst_bus_err", 32'(bus_err), 32'h0);
        chk("rst_err_addr", err_addr, 32'h0);
        chk("rst_err_irq", 32'(err_irq), 32'h0);
        reset_n = 1'b1;

        // Read from slave0, ready one cycle after select.
        cyc();
        request(32'h0000_0100, 4'h0, 1'b0, 32'h1234_5678);
        slv_rdata[31:0] = 32'h1234_5678;
        #1;
        chk("t1_c0_sel", 32'(slv_sel), 32'h0);
        chk("t1_c0_ready", 32'(mem_ready), 32'h0);
        cyc(); #1;
        chk("t1_c1_sel", 32'(slv_sel), 32'h1);
        chk("t1_c1_ready", 32'(mem_ready), 32'h0);
        slv_ready[0] = 1'b1; #1;
        chk_resp("t1_c2");
        cyc();
        mem_valid = 1'b0; slv_ready = '0; #1;
        chk("t1_c3_sel", 32'(slv_sel), 32'h0);
        chk("t1_c3_rdata", mem_rdata, 32'h0);

        // Write to slave2 while slave0 drives a stray ready.
        cyc();
        request(32'h8000_000C, 4'hF, 1'b0, 32'h0000_0002);
        slv_rdata[95:64] = 32'h0000_0002;
        slv_rdata[31:0]  = 32'hBAD0_0000;
        slv_ready[0] = 1'b1; #1;
        chk("t2_c0_ready", 32'(mem_ready), 32'h0);
        chk("t2_c0_wstrb", 32'(slv_wstrb), 32'h0);
        cyc(); #1;
        chk("t2_c1_sel", 32'(slv_sel), 32'h4);
        chk("t2_c1_ready", 32'(mem_ready), 32'h0);
        chk("t2_c1_wstrb", 32'(slv_wstrb), 32'hF);
        chk("t2_c1_wdata", slv_wdata, 32'h8000_000C ^ 32'h5A5A_5A5A);
        slv_ready[2] = 1'b1; #1;
        chk_resp("t2_c2");
        cyc();
        mem_valid = 1'b0; slv_ready = '0; #1;
        chk("t2_c3_sel", 32'(slv_sel), 32'h0);

        // Unmapped instruction fetch.
        cyc();
        request(32'h4000_0000, 4'h0, 1'b1, 32'hDEAD_BEEF); #1;
        chk("t3_c0_ready", 32'(mem_ready), 32'h0);
        chk("t3_c0_irq", 32'(err_irq), 32'h0);
        cyc(); #1;
        chk_resp("t3_c1");
        chk("t3_c1_irq", 32'(err_irq), 32'h1);
        chk("t3_c1_bus_err", 32'(bus_err), 32'h1);
        chk("t3_c1_err_addr", err_addr, 32'h4000_0000);
        chk("t3_c1_err_instr", 32'(err_instr), 32'h1);
        chk("t3_c1_sel", 32'(slv_sel), 32'h0);
        cyc();
        mem_valid = 1'b0; #1;
        chk("t3_c2_irq", 32'(err_irq), 32'h0);
        chk("t3_c2_ready", 32'(mem_ready), 32'h0);
        chk("t3_c2_bus_err", 32'(bus_err), 32'h1);

        // Clear the sticky flag; the recorded address is left alone.
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0; #1;
        chk("clr_bus_err", 32'(bus_err), 32'h0);
        chk("clr_err_addr", err_addr, 32'h4000_0000);

        // Slave3 never answers: eight selected cycles, then an error response.
        request(32'h8000_0010, 4'h0, 1'b0, 32'hDEAD_BEEF);
        for (int k = 1; k <= 8; k++) begin
            cyc(); #1;
            chk($sformatf("t4_sel_%0d", k), 32'(slv_sel), 32'h8);
            chk($sformatf("t4_ready_%0d", k), 32'(mem_ready), 32'h0);
        end
        cyc(); #1;
        chk("t4_err_sel", 32'(slv_sel), 32'h0);
        chk_resp("t4_err");
        chk("t4_err_irq", 32'(err_irq), 32'h1);
        chk("t4_err_bus_err", 32'(bus_err), 32'h1);
        chk("t4_err_addr", err_addr, 32'h8000_0010);
        chk("t4_err_instr", 32'(err_instr), 32'h0);
        cyc();
        mem_valid = 1'b0; #1;
        chk("t4_post_irq", 32'(err_irq), 32'h0);

        // Second error while the flag is set keeps the first address.
        cyc();
        request(32'h5000_0000, 4'h0, 1'b0, 32'hDEAD_BEEF);
        cyc(); #1;
        chk_resp("t5a");
        chk("t5a_irq", 32'(err_irq), 32'h1);
        chk("t5a_err_addr", err_addr, 32'h8000_0010);
        cyc();
        mem_valid = 1'b0;

        // Clear coincident with a new error: set wins, address refreshed.
        cyc();
        request(32'h6000_0000, 4'h0, 1'b0, 32'hDEAD_BEEF);
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0; #1;
        chk_resp("t5b");
        chk("t5b_bus_err", 32'(bus_err), 32'h1);
        chk("t5b_err_addr", err_addr, 32'h6000_0000);
        cyc();
        mem_valid = 1'b0;

        // Asynchronous reset in the middle of an access to slave1.
        cyc();
        mem_valid = 1'b1; mem_addr = 32'h8000_0000; mem_wstrb = 4'h0;
        slv_rdata[63:32] = 32'h1111_1111;
        cyc(); #1;
        chk("t6_sel", 32'(slv_sel), 32'h2);
        slv_ready[1] = 1'b1; #1;
        chk("t6_ready_pre", 32'(mem_ready), 32'h1);
        #1 reset_n = 1'b0; #1;
        chk("t6_rst_sel", 32'(slv_sel), 32'h0);
        chk("t6_rst_ready", 32'(mem_ready), 32'h0);
        chk("t6_rst_bus_err", 32'(bus_err), 32'h0);
        chk("t6_rst_err_addr", err_addr, 32'h0);
        mem_valid = 1'b0; slv_ready = '0;
        cyc();
        reset_n = 1'b1;

        // Fresh read after reset, slave ready as soon as it is selected.
        cyc();
        request(32'h0000_0200, 4'h0, 1'b0, 32'hCAFE_F00D);
        slv_rdata[31:0] = 32'hCAFE_F00D;
        slv_ready[0] = 1'b1; #1;
        chk("t7_c0_ready", 32'(mem_ready), 32'h0);
        cyc(); #1;
        chk("t7_c1_sel", 32'(slv_sel), 32'h1);
        chk_resp("t7_c1");
        cyc();
        mem_valid = 1'b0; slv_ready = '0; #1;
        chk("t7_c2_sel", 32'(slv_sel), 32'h0);
        chk("t7_c2_bus_err", 32'(bus_err), 32'h0);

        chk("sb_empty", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
